// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: status encodings, FSM states
// and the prefetch buffer entry.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [3:0] {
        FWD_IDLE      = 4'h0,
        FWD_VALID     = 4'h1,
        FWD_BUS_ERROR = 4'h2
    } status_fwd_e;

    typedef enum logic [1:0] {
        BWD_READY = 2'b00,
        BWD_STALL = 2'b01,
        BWD_JUMP  = 2'b10
    } status_bwd_e;

    typedef enum logic [1:0] {
        S_FETCH     = 2'd0,
        S_WAIT_ROOM = 2'd1,
        S_FLUSH     = 2'd2,
        S_HALT      = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            err;
    } fetch_entry_t;

    // Forward status an entry presents with once it reaches the output stage.
    function automatic status_fwd_e entry_status(input fetch_entry_t e);
        return e.err ? FWD_BUS_ERROR : FWD_VALID;
    endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Power-of-two prefetch buffer of fetch entries with a synchronous flush.
module fetch_prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output fetch_entry_t                 head_c,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_d;

    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign count_d = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign head_c  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/fetch_stage_prefetch.sv
// Instruction fetch stage: pipelined Wishbone classic fetches into a prefetch
// buffer feeding a registered decode-facing output stage.
module fetch_stage_prefetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned PREFETCH_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_mosi,
    input  logic [31:0] wb_dat_miso,
    input  logic        wb_ack,
    input  logic        wb_err,
    output logic [3:0]  status_forwards_out,
    input  logic [1:0]  status_backwards_in,
    input  logic [31:0] jump_address_backwards_in,
    output logic [31:0] instruction_reg_out,
    output logic [31:0] program_counter_reg_out
);

    localparam int unsigned CNT_W = $clog2(PREFETCH_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e     state;
    fetch_state_e     state_d;
    logic [31:0]      fetch_pc;
    logic [31:0]      fetch_pc_d;
    logic             cyc_d;
    logic [31:0]      adr_d;

    logic             jump;
    logic             ready;
    logic             ack_v;
    logic             err_v;
    logic             term;
    logic             push;
    logic             out_valid;
    logic             consume;
    logic             out_free;
    logic             use_bypass;
    logic             fifo_push;
    logic             fifo_pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] occ_next;
    status_fwd_e      status_q;

    assign wb_stb      = wb_cyc;
    assign wb_we       = 1'b0;
    assign wb_sel      = 4'hF;
    assign wb_dat_mosi = 32'h0;
    assign status_forwards_out = status_q;

    assign jump  = (status_backwards_in == BWD_JUMP);
    assign ready = (status_backwards_in == BWD_READY);
    assign ack_v = wb_cyc && wb_ack && !wb_err;
    assign err_v = wb_cyc && wb_err;
    assign term  = ack_v || err_v;

    // A jump discards whatever returns in the same cycle.
    assign push       = (state == S_FETCH) && term && !jump;
    assign push_entry = {(err_v ? 32'h0 : wb_dat_miso), fetch_pc, err_v};

    assign out_valid  = (status_q != FWD_IDLE);
    assign consume    = out_valid && ready;
    assign out_free   = !out_valid || consume;
    assign use_bypass = push && out_free && fifo_empty;
    assign fifo_pop   = out_free && !fifo_empty && !jump;
    assign fifo_push  = push && !use_bypass && (!fifo_full || fifo_pop);

    // Entries held after this edge (buffer plus output stage); one more may be in flight.
    assign occ_next = OCC_W'(fifo_count) + OCC_W'(out_valid) + OCC_W'(push) - OCC_W'(consume);

    fetch_prefetch_fifo #(
        .DEPTH (PREFETCH_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (jump),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head_c     (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (jump) begin
            state_d = (wb_cyc && !term) ? S_FLUSH : S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (err_v) begin
                        state_d = S_HALT;
                    end else if (occ_next > OCC_W'(PREFETCH_DEPTH)) begin
                        state_d = S_WAIT_ROOM;
                    end
                end
                S_WAIT_ROOM: begin
                    if (occ_next <= OCC_W'(PREFETCH_DEPTH)) begin
                        state_d = S_FETCH;
                    end
                end
                S_FLUSH: begin
                    if (term) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // Bus request for the next cycle; a flushing access keeps its original address.
    always_comb begin
        fetch_pc_d = fetch_pc;
        if (jump) begin
            fetch_pc_d = jump_address_backwards_in & 32'hFFFF_FFFC;
        end else if (push && ack_v) begin
            fetch_pc_d = fetch_pc + 32'd4;
        end
        cyc_d = (state_d == S_FETCH) || (state_d == S_FLUSH);
        adr_d = (state_d == S_FLUSH) ? wb_adr : fetch_pc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc   <= 1'b0;
            wb_adr   <= 32'h0;
            fetch_pc <= RESET_VECTOR;
        end else begin
            wb_cyc   <= cyc_d;
            wb_adr   <= adr_d;
            fetch_pc <= fetch_pc_d;
        end
    end

    // Output stage: refill from the buffer head, else bypass a fresh response.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q                <= FWD_IDLE;
            instruction_reg_out     <= 32'h0;
            program_counter_reg_out <= 32'h0;
        end else if (jump) begin
            status_q <= FWD_IDLE;
        end else if (out_free) begin
            if (!fifo_empty) begin
                status_q                <= entry_status(fifo_head);
                instruction_reg_out     <= fifo_head.instr;
                program_counter_reg_out <= fifo_head.pc;
            end else if (use_bypass) begin
                status_q                <= entry_status(push_entry);
                instruction_reg_out     <= push_entry.instr;
                program_counter_reg_out <= push_entry.pc;
            end else begin
                status_q <= FWD_IDLE;
            end
        end
    end

endmodule

// File: doc/fetch_stage_prefetch.md
# fetch_stage_prefetch

Parametrised instruction fetch stage with a Wishbone classic master port, a PREFETCH_DEPTH-entry prefetch buffer and back-to-back (pipelined-address) fetching. It sits at the front of the core pipeline, feeding instruction/PC pairs to decode. It accepts stall and jump requests from downstream over the backwards status channel, and reports bus errors forwards in-band.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- PREFETCH_DEPTH, 4, buffer entries; power of two, at least 2.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; synchronous and active-high.
- wb_cyc, wb_stb  out  1  Wishbone cycle/strobe.
- wb_we  out  1  constant 0.
- wb_sel  out  4  constant 4'hF.
- wb_adr  out  32  fetch address, word aligned.
- wb_dat_mosi  out  32  constant 0.
- wb_dat_miso  in  32  fetched instruction.
- wb_ack, wb_err  in  1  terminate the current access; wb_err has priority if both are high.
- status_forwards_out  out  4  values: IDLE=4'h0, VALID=4'h1, BUS_ERROR=4'h2.
- status_backwards_in  in  2  values: READY=2'b00, STALL=2'b01, JUMP=2'b10; 2'b11 is treated as STALL.
- jump_address_backwards_in  in  32  jump target; sampled only when status is JUMP.
- instruction_reg_out  out  32  instruction presented to decode.
- program_counter_reg_out  out  32  PC of the presented instruction.

## Operation
- Registers:
  - fetch_pc: next address to request.
  - Prefetch FIFO: each entry holds {instr, pc, err}.
  - Output stage register.
- FSM states: FETCH, WAIT_ROOM, FLUSH, HALT.
- FETCH:
  - wb_cyc = wb_stb = 1, wb_adr = fetch_pc.
  - On wb_ack: push {dat_miso, fetch_pc, 0}, then fetch_pc += 4 (wraps mod 2^32).
  - If room remains after the push, stay in FETCH and present the next address in the following cycle. Otherwise go to WAIT_ROOM with cyc/stb low.
- Room: occupancy of FIFO + output stage + the in-flight access must stay ≤ PREFETCH_DEPTH+1.
- WAIT_ROOM: bus idle. Return to FETCH on the edge at which a slot frees.
- Output stage:
  - Loads from the FIFO head when it is empty, or when it is consumed (status VALID/BUS_ERROR with READY).
  - If the FIFO is empty and an ack arrives, the data bypasses straight into the output stage.
- Consume: READY while the output holds an entry. STALL holds the outputs unchanged.
- JUMP (highest priority, any state except reset):
  - Flush the FIFO and the output stage; outputs go to IDLE next cycle.
  - fetch_pc ← {jump_address[31:2], 2'b00}.
  - If an access is outstanding (cyc high, no ack/err this cycle), go to FLUSH.
  - Otherwise go to FETCH with the new address in the next cycle.
- FLUSH:
  - Keep cyc/stb asserted until ack or err, then discard the result and enter FETCH.
  - A second JUMP during FLUSH overwrites fetch_pc.
- wb_err in FETCH:
  - Push {32'h0, fetch_pc, 1}, then enter HALT with the bus idle and fetch_pc unchanged.
  - The error entry presents as BUS_ERROR with instruction 0.
  - HALT exits only on JUMP.
- JUMP takes priority over a same-cycle ack/err: the returning data is discarded and no FLUSH is needed.

## Timing
- Reset values:
  - All outputs 0; status IDLE.
  - FIFO empty; fetch_pc = RESET_VECTOR; state FETCH.
- First request: cyc/stb are high in the first cycle after rst deasserts, with wb_adr = RESET_VECTOR.
- Latency: ack sampled at edge k → instruction VALID on the outputs from edge k (visible in cycle k+1), provided the FIFO is empty and the output is free.
- Throughput: with zero-wait ack and READY held, one instruction per cycle.
- JUMP sampled at edge k:
  - Status is IDLE after edge k.
  - If no access is outstanding, the new address is on wb_adr in cycle k+1.
- rst mid-access: cyc/stb drop after the edge; any later ack is ignored.

## Structure
- fetch_pkg:
  - status_fwd_e and status_bwd_e encodings.
  - fetch_state_e.
  - fetch_entry_t struct {instr, pc, err}.
- Sub-module fetch_prefetch_fifo:
  - Parametrised by depth; synchronous flush input.
  - Flags: count, full, empty.
  - Ports: push, pop.
- Top level: FSM, output stage, bypass and room logic.

## Test plan
- Reset, zero-wait memory, READY held → first wb_adr 0x0. Outputs present PC 0x0, 0x4, 0x8 on consecutive cycles, each with its memory word, status VALID.
- STALL held from the first VALID, DEPTH=4:
  - Exactly 5 acks are accepted (4 in the FIFO plus 1 in the output stage), then cyc drops.
  - After READY, 5 instructions drain in order and fetching resumes at 0x14.
- 3-wait-state memory, JUMP to 0x100 in cycle 1 of an access:
  - cyc stays high until the ack, the data is discarded and the next wb_adr is 0x100.
  - No output shows the stale word.
- wb_err at address 0x8:
  - Outputs show PC 0x8, status BUS_ERROR, instruction 0; no further cyc.
  - JUMP to 0x200 resumes fetching there.
- JUMP to 0x103 → wb_adr 0x100.
- rst asserted during an outstanding access → outputs 0, status IDLE, next request at RESET_VECTOR.
